// File: rtl/cla_slice_sequencer_if.sv
// ---------------------------------------------------------------------------
// cla_slice_sequencer_if
//
// Purpose: bundles every non-clock signal of the CLA slice sequencer into one
// interface. It carries three groups of signals:
//   request : in_valid, in_ready, in_a, in_b, in_sub, in_cin
//   slice   : slice_a, slice_b, slice_cin, slice_sum, slice_cout
//   result  : out_valid, out_ready, out_sum, out_cout, busy
//
// Modports:
//   slave  - the sequencer's view. It receives requests, drives the slice
//            inputs and presents the result.
//   master - the environment's view. It drives requests, models the external
//            combinational slice and consumes results.
// ---------------------------------------------------------------------------
interface cla_slice_sequencer_if #(
    parameter int NBIT  = 4,
    parameter int WIDTH = 16
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;

    logic [NBIT-1:0]  slice_a;
    logic [NBIT-1:0]  slice_b;
    logic             slice_cin;
    logic [NBIT-1:0]  slice_sum;
    logic             slice_cout;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             busy;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin,
        input  slice_sum, slice_cout,
        input  out_ready,
        output in_ready,
        output slice_a, slice_b, slice_cin,
        output out_valid, out_sum, out_cout, busy
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin,
        output slice_sum, slice_cout,
        output out_ready,
        input  in_ready,
        input  slice_a, slice_b, slice_cin,
        input  out_valid, out_sum, out_cout, busy
    );

endinterface

// File: rtl/cla_slice_sequencer.sv
// ---------------------------------------------------------------------------
// cla_slice_sequencer
//
// Purpose: computes a WIDTH-bit add or subtract by time-sharing a single
// external NBIT-wide combinational CLA slice. The sequencer feeds one chunk
// per cycle, starting with the least significant chunk. The carry-out of each
// chunk is registered and becomes the carry-in of the next chunk.
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - cla_slice_sequencer_if.slave, which contains three groups:
//             request : in_valid/in_ready handshake, in_a, in_b, in_sub, in_cin
//             slice   : slice_a, slice_b, slice_cin out; slice_sum, slice_cout in
//             result  : out_valid/out_ready handshake, out_sum, out_cout, busy
//
// Timing: the accept edge is followed by NCHUNK RUN cycles and then DONE.
// DONE holds until out_ready is high, after which the sequencer returns to
// IDLE.
// ---------------------------------------------------------------------------
module cla_slice_sequencer #(
    parameter  int NBIT   = 4,
    parameter  int WIDTH  = 16,
    localparam int NCHUNK = WIDTH / NBIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    cla_slice_sequencer_if.slave   bus
);

    localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // A partial final chunk would need a masked slice, which this datapath
    // does not support, so such configurations are refused at elaboration.
    generate
        if ((NBIT < 1) || (WIDTH % NBIT != 0)) begin : g_badWidth
            $error("cla_slice_sequencer: WIDTH must be a positive multiple of NBIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             w_accept;
    logic             w_lastChunk;

    assign w_accept    = (r_state == IDLE) && bus.in_valid;
    assign w_lastChunk = (r_cnt == CW'(NCHUNK - 1));

    // State register. A reset at any point drops back to IDLE. Any operation
    // in flight is lost and produces no result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic. RUN always lasts exactly NCHUNK cycles, because the
    // transition to DONE happens on the same edge that consumes the last
    // chunk.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: if (w_accept)      w_nextState = RUN;
            RUN:  if (w_lastChunk)   w_nextState = DONE;
            DONE: if (bus.out_ready) w_nextState = IDLE;
            default:                 w_nextState = IDLE;
        endcase
    end

    // Datapath registers. Subtraction is performed as A + ~B + 1. The
    // inversion of B is applied once at capture time, and the +1 is supplied
    // by seeding the carry register, so the slice only ever sees an add.
    // While in RUN, each edge stores the slice result into the current chunk
    // of the sum and forwards the slice carry-out to the next chunk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= bus.in_a;
                        r_b     <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        r_carry <= bus.in_sub ? 1'b1 : bus.in_cin;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_sum[r_cnt*NBIT +: NBIT] <= bus.slice_sum;
                    r_carry                   <= bus.slice_cout;
                    r_cnt                     <= w_lastChunk ? '0 : r_cnt + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs. The slice inputs are zero outside RUN, so the external slice
    // sees quiet inputs while the sequencer is idle. The result outputs are
    // only non-zero in DONE. Because the registers are frozen in DONE, the
    // result stays stable for as long as the sink applies backpressure.
    always_comb begin
        bus.in_ready  = (r_state == IDLE);
        bus.busy      = (r_state == RUN) || (r_state == DONE);
        bus.slice_a   = '0;
        bus.slice_b   = '0;
        bus.slice_cin = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
        if (r_state == RUN) begin
            bus.slice_a   = r_a[r_cnt*NBIT +: NBIT];
            bus.slice_b   = r_b[r_cnt*NBIT +: NBIT];
            bus.slice_cin = r_carry;
        end
        if (r_state == DONE) begin
            bus.out_valid = 1'b1;
            bus.out_sum   = r_sum;
            bus.out_cout  = r_carry;
        end
    end

endmodule

// File: tb/tb_cla_slice_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cla_slice_sequencer
//
// Purpose: directed testbench for cla_slice_sequencer with NBIT=4 and
// WIDTH=16. The external CLA slice is modelled as a plain (NBIT+1)-bit adder.
// Every expected result below was worked out by hand from the operands.
// ---------------------------------------------------------------------------
module tb_cla_slice_sequencer;

    localparam int NBIT   = 4;
    localparam int WIDTH  = 16;
    localparam int NCHUNK = WIDTH / NBIT;

    logic clk;
    logic rst_n;
    int   testCount;
    int   failCount;

    cla_slice_sequencer_if #(.NBIT(NBIT), .WIDTH(WIDTH)) bus ();

    cla_slice_sequencer #(.NBIT(NBIT), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Behavioural model of the external combinational slice.
    assign {bus.slice_cout, bus.slice_sum} = {1'b0, bus.slice_a} + {1'b0, bus.slice_b}
                                           + {{NBIT{1'b0}}, bus.slice_cin};

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares one observed value against its expected value. On a mismatch
    // it counts the failure and reports the tag with both values.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request on the input side and raises in_valid.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sub   = sub;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
    endtask

    // Runs one complete operation. It checks the latency from accept to
    // result, the result value, and result stability over `hold` cycles of
    // backpressure. After the result is consumed it checks the return to
    // IDLE. The carry-in seen by each chunk is returned in cins.
    task automatic runOp(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic cin,
                         input logic [15:0] expSum, input logic expCout,
                         input int hold, output logic [3:0] cins);
        int lat;
        @(negedge clk);
        applyStimulus(a, b, sub, cin);
        checkOutput({tag, "_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat  = 1;
        cins = '0;
        while (!bus.out_valid && lat < 50) begin
            if (lat <= NCHUNK) cins[lat-1] = bus.slice_cin;
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, 32'(lat), 32'(NCHUNK + 1));
        checkOutput({tag, "_sum"},     32'(bus.out_sum),  32'(expSum));
        checkOutput({tag, "_cout"},    32'(bus.out_cout), 32'(expCout));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, "_bp_sum"},   32'(bus.out_sum),   32'(expSum));
            checkOutput({tag, "_bp_cout"},  32'(bus.out_cout),  32'(expCout));
            checkOutput({tag, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
            checkOutput({tag, "_bp_ready"}, 32'(bus.in_ready),  32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput({tag, "_idle_ready"}, 32'(bus.in_ready),  32'd1);
        checkOutput({tag, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Directed test sequence.
    initial begin
        logic [3:0]  cins;
        logic        staleSeen;
        int          acceptCyc [2];
        logic [15:0] resSum [2];
        logic        resCout [2];
        int          nAcc;
        int          nRes;
        logic        pendingAccept;

        testCount     = 0;
        failCount     = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sub    = 1'b0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst_valid",   32'(bus.out_valid), 32'd0);
        checkOutput("rst_sum",     32'(bus.out_sum),   32'd0);
        checkOutput("rst_slice_a", 32'(bus.slice_a),   32'd0);
        checkOutput("rst_busy",    32'(bus.busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Add with carries between chunks: 0x1234 + 0x0FCD = 0x2201.
        // The chunk carry-ins are 0,1,1,1 from LSB to MSB.
        runOp("add_chain", 16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 0, cins);
        checkOutput("add_chain_cins", 32'(cins), 32'b1110);

        // Full ripple through all chunks.
        runOp("ripple_b1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, cins);
        runOp("ripple_cin", 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 0, cins);

        // Subtract. in_cin is driven to the opposite value in each case to
        // confirm that it is ignored when subtracting.
        runOp("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 0, cins);
        runOp("sub_ok",     16'h0007, 16'h0005, 1'b1, 1'b0, 16'h0002, 1'b1, 0, cins);
        checkOutput("sub_ok_cins", 32'(cins[0]), 32'd1);

        // Backpressure: 0x00FF + 0x0F01 = 0x1000, held for 10 cycles.
        runOp("backpressure", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 10, cins);

        // Reset in the middle of RUN aborts the operation.
        @(negedge clk);
        applyStimulus(16'hAAAA, 16'h5555, 1'b0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy_before", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_busy",  32'(bus.busy),      32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_ready", 32'(bus.in_ready), 32'd1);
        staleSeen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            staleSeen = staleSeen | bus.out_valid;
        end
        checkOutput("midrst_no_stale", 32'(staleSeen), 32'd0);
        runOp("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 0, cins);

        // Back-to-back: in_valid is held high across two queued requests
        // while the sink is always ready. The second request is
        // 0x8000 - 0x0001 = 0x7FFF with cout=1.
        nAcc          = 0;
        nRes          = 0;
        pendingAccept = 1'b0;
        acceptCyc[0]  = -100;
        acceptCyc[1]  = 0;
        resSum[0]     = 'x;
        resSum[1]     = 'x;
        resCout[0]    = 1'bx;
        resCout[1]    = 1'bx;
        bus.out_ready = 1'b1;
        @(negedge clk);
        applyStimulus(16'h1234, 16'h0FCD, 1'b0, 1'b0);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (pendingAccept) begin
                pendingAccept = 1'b0;
                if (nAcc == 1) applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b0);
                else           bus.in_valid = 1'b0;
            end
            if (bus.in_valid && bus.in_ready && nAcc < 2) begin
                acceptCyc[nAcc] = cyc;
                nAcc++;
                pendingAccept = 1'b1;
            end
            if (bus.out_valid && nRes < 2) begin
                resSum[nRes]  = bus.out_sum;
                resCout[nRes] = bus.out_cout;
                nRes++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checkOutput("b2b_accepts",  32'(nAcc), 32'd2);
        checkOutput("b2b_results",  32'(nRes), 32'd2);
        checkOutput("b2b_spacing",  32'(acceptCyc[1] - acceptCyc[0]), 32'(NCHUNK + 2));
        checkOutput("b2b_sum0",     32'(resSum[0]),  32'h2201);
        checkOutput("b2b_cout0",    32'(resCout[0]), 32'd0);
        checkOutput("b2b_sum1",     32'(resSum[1]),  32'h7FFF);
        checkOutput("b2b_cout1",    32'(resCout[1]), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/cla_slice_sequencer.md
Name: cla_slice_sequencer

Overview:
- Multi-cycle controller that computes a WIDTH-bit add/subtract by time-sharing one NBIT-wide decomposed CLA slice (non-linear plus linear parts).
- Feeds one NBIT chunk per cycle, LSB chunk first, and chains the slice carry-out back as the next chunk's carry-in.
- Sits between a valid/ready request source and a valid/ready result sink.
- The slice is external and combinational; its outputs are sampled in the same cycle the controller drives its inputs.

Parameters:
- NBIT, 4, width of the shared CLA slice.
- WIDTH, 16, operand width; must be an integer multiple of NBIT (elaboration error otherwise).
- NCHUNK, WIDTH/NBIT, derived number of chunks; not to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  controller can accept a request.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  1 = A-B, 0 = A+B.
- in_cin  in  1  carry-in for add; ignored when in_sub=1.
- slice_a  out  NBIT  current A chunk to slice.
- slice_b  out  NBIT  current B chunk to slice, inverted when subtracting.
- slice_cin  out  1  carry into slice.
- slice_sum  in  NBIT  slice sum return.
- slice_cout  in  1  slice carry-out return.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- out_sum  out  WIDTH  result.
- out_cout  out  1  final carry-out (for subtract, 1 = no borrow).
- busy  out  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset, asynchronous on rst_n low:
  - state=IDLE.
  - Chunk counter=0; operand, sum and carry registers=0.
  - out_valid=0, out_sum=0, out_cout=0.
  - slice_a, slice_b, slice_cin=0.
  - in_ready=1 once rst_n is released.
- A reset asserted mid-operation aborts the operation. No result is produced.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture in_a and in_b. When in_sub=1, the captured B is ~in_b.
  - Carry register := in_sub ? 1 : in_cin.
  - Counter := 0, then go to RUN.
- RUN:
  - in_ready=0.
  - slice_a = A chunk[counter]; slice_b = B' chunk[counter]; slice_cin = carry register.
  - On each clk edge: sum chunk[counter] := slice_sum, carry register := slice_cout, counter++.
  - When counter==NCHUNK-1, go to DONE on that same edge.
  - RUN lasts exactly NCHUNK cycles.
- slice_a, slice_b and slice_cin are 0 outside RUN.
- DONE:
  - out_valid=1; out_sum = sum register; out_cout = carry register.
  - Outputs are held stable while out_ready=0 (backpressure of unbounded length).
  - On out_ready=1, go to IDLE; out_valid drops on the next cycle.
- Latency: accept edge to out_valid high = NCHUNK+1 cycles.
- Minimum spacing between accepts = NCHUNK+2 cycles.
- No request is accepted in the cycle the result is consumed.
- in_valid while not IDLE is ignored (held by the source per valid/ready rules).
- out_ready while not in DONE has no effect.
- Arithmetic is modulo 2^WIDTH; the carry-out is the WIDTH+1-th bit.
- NCHUNK=1 degenerates to one RUN cycle.

Test Plan:
- Reset: rst_n low mid-RUN, then released → out_valid=0, in_ready=1, no stale result appears. Next op 0x0001+0x0001 → 0x0002, cout=0.
- Add with inter-chunk carries, WIDTH=16, NBIT=4: A=0x1234, B=0x0FCD, sub=0, cin=0 → out_sum=0x2201, out_cout=0, out_valid exactly 5 cycles after accept. Chunk carries observed on slice_cin: 0,1,1,1.
- Full ripple: A=0xFFFF, B=0x0001, cin=0 → out_sum=0x0000, out_cout=1. Same with B=0x0000, cin=1 → same result.
- Subtract with borrow: A=0x0005, B=0x0007, sub=1 → out_sum=0xFFFE, out_cout=0. A=0x0007, B=0x0005, sub=1 → 0x0002, out_cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_sum and out_cout stable, in_ready=0. Assert out_ready → IDLE next cycle, in_ready=1.
- Back-to-back: in_valid held high with two queued requests → second accept occurs exactly NCHUNK+2 cycles after the first. Both results are correct and in order.
